// File: rtl/froc_seq_pkg.sv
// Shared types and default parameters for the FROC test sequencer.
// Optional feature macro: FROC_SEQ_STOP_ON_ERROR_EN.
package froc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST_HOLD,
        START,
        RUN,
        DONE
    } seq_state_t;

    localparam int DEF_RESET_CYCLES = 4;
    localparam int DEF_START_CYCLES = 4;
    localparam int DEF_MAX_CYCLE    = 1000;
    localparam int DEF_DONE_CYCLES  = 4;
    localparam int DEF_CNT_W        = 32;

endpackage

// File: rtl/froc_test_sequencer_if.sv
// Control/status bundle between the sequencer and its DUT/controller.
// Optional feature macro: FROC_SEQ_STOP_ON_ERROR_EN.
interface froc_test_sequencer_if
    import froc_seq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             go;
    logic             error;
    logic             dut_reset;
    logic             start_test;
    logic             done;
    logic             busy;
    logic [CNT_W-1:0] cycle;
    logic [CNT_W-1:0] err_count;
    logic             first_err_valid;
    logic [CNT_W-1:0] first_err_cycle;

    modport master (
        input  go, error,
        output dut_reset, start_test, done, busy,
        output cycle, err_count,
        output first_err_valid, first_err_cycle
    );

    modport slave (
        output go, error,
        input  dut_reset, start_test, done, busy,
        input  cycle, err_count,
        input  first_err_valid, first_err_cycle
    );
endinterface

// File: rtl/froc_sat_counter.sv
// Saturating up-counter with synchronous clear and enable.
// Optional feature macro: FROC_SEQ_STOP_ON_ERROR_EN (not used here).
module froc_sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && cnt_q != '1)
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge CLK) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/froc_test_sequencer.sv
// Cycle-exact reset/start/run/done sequencer with DUT error statistics.
// Optional feature macro: FROC_SEQ_STOP_ON_ERROR_EN (end RUN on first error).
module froc_test_sequencer
    import froc_seq_pkg::*;
#(
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int START_CYCLES = DEF_START_CYCLES,
    parameter int MAX_CYCLE    = DEF_MAX_CYCLE,
    parameter int DONE_CYCLES  = DEF_DONE_CYCLES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input logic                  CLK,
    input logic                  reset,
    froc_test_sequencer_if.master bus
);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYCLE);

    seq_state_t       state_q, state_d;
    logic [31:0]      tmr_q, tmr_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] fec_q, fec_d;
    logic             fev_q, fev_d;
    logic             dut_reset_q, start_q, done_q, busy_q;
    logic             run_err, clr, last_run;

    assign run_err = (state_q == RUN) && bus.error;
    assign clr     = (state_q == IDLE) && bus.go;

`ifdef FROC_SEQ_STOP_ON_ERROR_EN
    assign last_run = (cycle_q == MAX_C) || bus.error;
`else
    assign last_run = (cycle_q == MAX_C);
`endif

    // Phase timer is reloaded with (length-1) on entry to each timed state
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        cycle_d = cycle_q;
        fev_d   = fev_q;
        fec_d   = fec_q;
        unique case (state_q)
            IDLE: begin
                if (bus.go) begin
                    state_d = RST_HOLD;
                    tmr_d   = 32'(RESET_CYCLES - 1);
                    cycle_d = '0;
                    fev_d   = 1'b0;
                    fec_d   = '0;
                end
            end
            RST_HOLD: begin
                if (tmr_q == '0) begin
                    state_d = START;
                    tmr_d   = 32'(START_CYCLES - 1);
                end else begin
                    tmr_d = tmr_q - 32'd1;
                end
            end
            START: begin
                if (tmr_q == '0)
                    state_d = RUN;
                else
                    tmr_d = tmr_q - 32'd1;
            end
            RUN: begin
                if (run_err && !fev_q) begin
                    fev_d = 1'b1;
                    fec_d = cycle_q;
                end
                if (last_run) begin
                    state_d = DONE;
                    tmr_d   = 32'(DONE_CYCLES - 1);
                end else begin
                    cycle_d = cycle_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (tmr_q == '0)
                    state_d = IDLE;
                else
                    tmr_d = tmr_q - 32'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= IDLE;
            tmr_q       <= '0;
            cycle_q     <= '0;
            fev_q       <= 1'b0;
            fec_q       <= '0;
            dut_reset_q <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            cycle_q     <= cycle_d;
            fev_q       <= fev_d;
            fec_q       <= fec_d;
            dut_reset_q <= (state_d == RST_HOLD);
            start_q     <= (state_d == START);
            done_q      <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    froc_sat_counter #(
        .W(CNT_W)
    ) u_err_cnt (
        .CLK  (CLK),
        .reset(reset),
        .clr_i(clr),
        .en_i (run_err),
        .cnt_o(bus.err_count)
    );

    assign bus.dut_reset       = dut_reset_q;
    assign bus.start_test      = start_q;
    assign bus.done            = done_q;
    assign bus.busy            = busy_q;
    assign bus.cycle           = cycle_q;
    assign bus.first_err_valid = fev_q;
    assign bus.first_err_cycle = fec_q;
endmodule

// File: tb/tb_froc_test_sequencer.sv
// Self-checking bench: scenario table, corner sequences, random vs model.
// Honours FROC_SEQ_STOP_ON_ERROR_EN when the RTL is built with it.
module tb_froc_test_sequencer;
    localparam int R0 = 4, S0 = 4, M0 = 10, D0 = 4, W0 = 32;
    localparam int R1 = 2, S1 = 1, M1 = 15, D1 = 3, W1 = 4;
`ifdef FROC_SEQ_STOP_ON_ERROR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic CLK = 1'b0;
    logic reset, go, error;
    always #5 CLK = ~CLK;

    froc_test_sequencer_if #(.CNT_W(W0)) b0 ();
    froc_test_sequencer_if #(.CNT_W(W1)) b1 ();
    assign b0.go = go;
    assign b0.error = error;
    assign b1.go = go;
    assign b1.error = error;

    froc_test_sequencer #(
        .RESET_CYCLES(R0), .START_CYCLES(S0), .MAX_CYCLE(M0),
        .DONE_CYCLES(D0), .CNT_W(W0)
    ) u0 (.CLK(CLK), .reset(reset), .bus(b0.master));

    froc_test_sequencer #(
        .RESET_CYCLES(R1), .START_CYCLES(S1), .MAX_CYCLE(M1),
        .DONE_CYCLES(D1), .CNT_W(W1)
    ) u1 (.CLK(CLK), .reset(reset), .bus(b1.master));

    // Model: t = cycles since the go edge; phases are plain intervals of t
    typedef struct {
        bit     act;
        int     t;
        int     run_end;
        longint cyc;
        longint cnt;
        bit     fv;
        longint fc;
    } mdl_t;

    typedef struct {
        logic [15:0] mask;
        longint      cnt;
        longint      fv;
        longint      fc;
        longint      cyc;
    } vec_t;

    mdl_t m0, m1;
    int   n_chk = 0, n_err = 0;

    function automatic void mstep(inout mdl_t m, input bit rst, g, e,
                                  input int R, S, M, D, input longint mx);
        if (rst) begin
            m = '{default: 0};
            return;
        end
        if (!m.act) begin
            if (g) begin
                m.act = 1; m.t = 0; m.run_end = R + S + M;
                m.cyc = 0; m.cnt = 0; m.fv = 0; m.fc = 0;
            end
            return;
        end
        if (m.t >= R + S && m.t <= m.run_end && e) begin
            if (m.cnt < mx) m.cnt++;
            if (!m.fv) begin
                m.fv = 1;
                m.fc = m.t - (R + S);
            end
            if (STOP) m.run_end = m.t;
        end
        if (m.t + 1 >= R + S && m.t + 1 <= m.run_end)
            m.cyc = m.t + 1 - (R + S);
        m.t++;
        if (m.t > m.run_end + D) m.act = 0;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input mdl_t m, input int R, S,
                       input logic [4:0] flags,
                       input longint cyc, cnt, fc);
        logic [4:0] ef;
        ef[4] = m.act && m.t < R;
        ef[3] = m.act && m.t >= R && m.t < R + S;
        ef[2] = m.act && m.t > m.run_end;
        ef[1] = m.act;
        ef[0] = m.fv;
        chk({tag, "_flags"}, longint'(flags), longint'(ef));
        chk({tag, "_cycle"}, cyc, m.cyc);
        chk({tag, "_errcnt"}, cnt, m.cnt);
        chk({tag, "_firstcyc"}, fc, m.fc);
    endtask

    task automatic tick();
        @(posedge CLK);
        mstep(m0, reset, go, error, R0, S0, M0, D0, 64'hFFFF_FFFF);
        mstep(m1, reset, go, error, R1, S1, M1, D1, 64'hF);
        #1;
        cmp("u0", m0, R0, S0,
            {b0.dut_reset, b0.start_test, b0.done, b0.busy, b0.first_err_valid},
            longint'(b0.cycle), longint'(b0.err_count), longint'(b0.first_err_cycle));
        cmp("u1", m1, R1, S1,
            {b1.dut_reset, b1.start_test, b1.done, b1.busy, b1.first_err_valid},
            longint'(b1.cycle), longint'(b1.err_count), longint'(b1.first_err_cycle));
    endtask

    task automatic run_seq(input logic [15:0] mask);
        int ndr = 0, nst = 0, ndn = 0;
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int k = 0; k < 200 && (m0.act || m1.act); k++) begin
            ndr += int'(b0.dut_reset);
            nst += int'(b0.start_test);
            ndn += int'(b0.done);
            error = m0.act && m0.t >= R0 + S0 && m0.t <= m0.run_end
                    && mask[m0.t - (R0 + S0)];
            tick();
            error = 1'b0;
        end
        chk("seq_end_busy", longint'(b0.busy), 0);
        chk("dut_reset_len", ndr, R0);
        chk("start_len", nst, S0);
        chk("done_len", ndn, D0);
    endtask

    vec_t vt[5];

    initial begin
        int idle0;
        longint sat_exp;
        vt[0] = '{16'h0000, 0, 0, 0, 10};
        if (!STOP) begin
            vt[1] = '{16'h0098, 3, 1, 3, 10};
            vt[2] = '{16'h0020, 1, 1, 5, 10};
            vt[3] = '{16'h0401, 2, 1, 0, 10};
            vt[4] = '{16'h07FF, 11, 1, 0, 10};
        end else begin
            vt[1] = '{16'h0098, 1, 1, 3, 3};
            vt[2] = '{16'h0020, 1, 1, 5, 5};
            vt[3] = '{16'h0401, 1, 1, 0, 0};
            vt[4] = '{16'h07FF, 1, 1, 0, 0};
        end
        m0 = '{default: 0};
        m1 = '{default: 0};
        reset = 1'b1; go = 1'b0; error = 1'b0;
        tick();
        tick();
        chk("reset_flags", longint'({b0.dut_reset, b0.start_test, b0.done,
                                     b0.busy, b0.first_err_valid}), 0);
        chk("reset_cycle", longint'(b0.cycle), 0);
        reset = 1'b0;
        tick();

        foreach (vt[i]) begin
            run_seq(vt[i].mask);
            tick();
            chk("vec_errcnt", longint'(b0.err_count), vt[i].cnt);
            chk("vec_fvalid", longint'(b0.first_err_valid), vt[i].fv);
            chk("vec_fcycle", longint'(b0.first_err_cycle), vt[i].fc);
            chk("vec_cycle", longint'(b0.cycle), vt[i].cyc);
        end

        // go held for a whole sequence, error only before RUN
        idle0 = 0;
        go = 1'b1;
        for (int k = 0; k < 30; k++) begin
            error = m0.act && m0.t < R0 + S0;
            if (m0.act && m0.t == R0 + S0)
                chk("no_err_pre_run", longint'(b0.err_count), 0);
            tick();
            if (!b0.busy) idle0++;
        end
        chk("go_held_idle_gap", idle0, 1);
        go = 1'b0; error = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // reset in RUN at cycle 6
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int k = 0; k < 50 && !(m0.act && m0.t == R0 + S0 + 6); k++)
            tick();
        chk("mid_cycle6", longint'(b0.cycle), 6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_flags", longint'({b0.dut_reset, b0.start_test, b0.done,
                                       b0.busy, b0.first_err_valid}), 0);
        chk("mid_rst_cycle", longint'(b0.cycle), 0);
        tick();

        // saturation on the 4-bit instance
        sat_exp = STOP ? 1 : 15;
        error = 1'b1;
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int k = 0; k < 80 && (m0.act || m1.act); k++)
            tick();
        error = 1'b0;
        tick();
        chk("sat_errcnt", longint'(b1.err_count), sat_exp);

        for (int k = 0; k < 3000; k++) begin
            go    = ($urandom % 8) == 0;
            error = ($urandom % 3) == 0;
            reset = ($urandom % 250) == 0;
            tick();
        end
        reset = 1'b0; go = 1'b0; error = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
